// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows the EX/MEM/WB destinations and decides stall, bubble, flush, freeze and operand forwarding.
// Define HAZARD_BYPASS_EN to enable forwarding; without it every in-flight producer interlocks.
module hazard_ctrl #(
    parameter int REG_FILE_LEN = 32,
    parameter int CNT_W        = 32,
    localparam int IDX_W       = $clog2(REG_FILE_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [IDX_W-1:0] id_src1_i,
    input  logic [IDX_W-1:0] id_src2_i,
    input  logic             id_use1_i,
    input  logic             id_use2_i,
    input  logic [IDX_W-1:0] id_dst_i,
    input  logic             id_we_i,
    input  logic             id_load_i,
    input  logic             flush_i,
    input  logic             mem_stall_i,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             flush_o,
    output logic             freeze_o,
    output logic [1:0]       fwd1_o,
    output logic [1:0]       fwd2_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] dst;
        logic             we;
        logic             load;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_INTERLOCK = 2'b01,
        ST_MEM_WAIT  = 2'b10
    } state_t;

    // Slot index 0 = EX, 1 = MEM, 2 = WB.
    slot_t          slot_q [3];
    slot_t          slot_d [3];
    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0] m1, m2, ld;
    logic       load_hz, hazard, issue;
    logic [1:0] fwd1_raw, fwd2_raw;

    for (genvar gi = 0; gi < 3; gi++) begin : g_match
        assign m1[gi] = slot_q[gi].valid & slot_q[gi].we & (slot_q[gi].dst == id_src1_i)
                        & (id_src1_i != '0) & id_use1_i;
        assign m2[gi] = slot_q[gi].valid & slot_q[gi].we & (slot_q[gi].dst == id_src2_i)
                        & (id_src2_i != '0) & id_use2_i;
        assign ld[gi] = slot_q[gi].load;
    end

    // A load in EX or MEM cannot be forwarded yet; its data exists only at WB.
    assign load_hz = |((m1 | m2) & ld & 3'b011);

`ifdef HAZARD_BYPASS_EN
    function automatic logic [1:0] fwd_sel(input logic [2:0] m, input logic [2:0] l);
        if (m[0] && !l[0])      return 2'b01;
        else if (m[1] && !l[1]) return 2'b10;
        else if (m[2])          return 2'b11;
        else                    return 2'b00;
    endfunction

    assign hazard   = load_hz;
    assign fwd1_raw = fwd_sel(m1, ld);
    assign fwd2_raw = fwd_sel(m2, ld);
`else
    assign hazard   = load_hz | (|(m1 | m2));
    assign fwd1_raw = 2'b00;
    assign fwd2_raw = 2'b00;
`endif

    assign issue  = id_valid_i & ~hazard & ~flush_i & ~mem_stall_i;
    assign fwd1_o = rst ? 2'b00 : fwd1_raw;
    assign fwd2_o = rst ? 2'b00 : fwd2_raw;

    always_comb begin
        stall_o  = 1'b0;
        bubble_o = 1'b0;
        flush_o  = 1'b0;
        freeze_o = 1'b0;
        if (mem_stall_i)  state_d = ST_MEM_WAIT;
        else if (hazard)  state_d = ST_INTERLOCK;
        else              state_d = ST_RUN;
        if (!rst) begin
            if (mem_stall_i) begin
                freeze_o = 1'b1;
                stall_o  = 1'b1;
            end else if (flush_i) begin
                flush_o  = 1'b1;
                bubble_o = 1'b1;
            end else if (hazard) begin
                stall_o  = 1'b1;
                bubble_o = 1'b1;
            end
        end
    end

    always_comb begin
        slot_d = slot_q;
        if (!mem_stall_i) begin
            slot_d[2] = slot_q[1];
            slot_d[1] = slot_q[0];
            slot_d[0] = issue ? {1'b1, id_dst_i, id_we_i, id_load_i} : '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((stall_o || freeze_o) && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) slot_q[i] <= '0;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            for (int i = 0; i < 3; i++) slot_q[i] <= slot_d[i];
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, all checked against an in-bench pipeline model.
module tb_hazard_ctrl;
    localparam int RFL   = 8;
    localparam int CNT_W = 4;
    localparam int IW    = $clog2(RFL);
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, id_valid_i, id_use1_i, id_use2_i, id_we_i, id_load_i, flush_i, mem_stall_i;
    logic [IW-1:0] id_src1_i, id_src2_i, id_dst_i;
    logic stall_o, bubble_o, flush_o, freeze_o;
    logic [1:0] fwd1_o, fwd2_o, state_o;
    logic [CNT_W-1:0] stall_cnt_o;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_FILE_LEN(RFL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i),
        .id_src1_i(id_src1_i), .id_src2_i(id_src2_i),
        .id_use1_i(id_use1_i), .id_use2_i(id_use2_i),
        .id_dst_i(id_dst_i), .id_we_i(id_we_i), .id_load_i(id_load_i),
        .flush_i(flush_i), .mem_stall_i(mem_stall_i),
        .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o), .freeze_o(freeze_o),
        .fwd1_o(fwd1_o), .fwd2_o(fwd2_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o)
    );

    // Model: in-flight instructions indexed by age (0 = one stage past ID).
    typedef struct { bit valid; int dst; bit we; bit load; } ent_t;
    ent_t pipe [3];
    int   m_state = 0;
    int   m_cnt   = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    bit   e_stall, e_bubble, e_flush, e_freeze, e_hz, e_issue, last_issue;
    int   e_f1, e_f2;

    function automatic bit hits(ent_t e, int src, bit use_b);
        return e.valid && e.we && (e.dst == src) && (src != 0) && use_b;
    endfunction

    task automatic model_eval();
        int s1 = int'(id_src1_i);
        int s2 = int'(id_src2_i);
        e_hz = 0; e_f1 = 0; e_f2 = 0;
        for (int a = 0; a < 3; a++) begin
            if (hits(pipe[a], s1, id_use1_i) || hits(pipe[a], s2, id_use2_i))
                if (!BYP || (pipe[a].load && a < 2)) e_hz = 1;
        end
        if (BYP) begin
            for (int a = 0; a < 3; a++) begin
                if (e_f1 == 0 && hits(pipe[a], s1, id_use1_i) && (!pipe[a].load || a == 2)) e_f1 = a + 1;
                if (e_f2 == 0 && hits(pipe[a], s2, id_use2_i) && (!pipe[a].load || a == 2)) e_f2 = a + 1;
            end
        end
        e_stall = 0; e_bubble = 0; e_flush = 0; e_freeze = 0;
        if (rst) begin
            e_f1 = 0; e_f2 = 0;
        end else if (mem_stall_i) begin
            e_freeze = 1; e_stall = 1;
        end else if (flush_i) begin
            e_flush = 1; e_bubble = 1;
        end else if (e_hz) begin
            e_stall = 1; e_bubble = 1;
        end
        e_issue = id_valid_i && !e_hz && !flush_i && !mem_stall_i;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step_check();
        @(negedge clk);
        model_eval();
        chk("stall", stall_o, e_stall);
        chk("bubble", bubble_o, e_bubble);
        chk("flush", flush_o, e_flush);
        chk("freeze", freeze_o, e_freeze);
        chk("fwd1", fwd1_o, e_f1);
        chk("fwd2", fwd2_o, e_f2);
        chk("state", state_o, m_state);
        chk("cnt", stall_cnt_o, m_cnt);
    endtask

    task automatic step_adv();
        @(posedge clk);
        last_issue = e_issue && !rst;
        if (rst) begin
            for (int a = 0; a < 3; a++) pipe[a] = '{0, 0, 0, 0};
            m_state = 0; m_cnt = 0;
        end else begin
            if ((e_stall || e_freeze) && m_cnt < CMAX) m_cnt++;
            m_state = mem_stall_i ? 2 : (e_hz ? 1 : 0);
            if (!mem_stall_i) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                if (e_issue) pipe[0] = '{1'b1, int'(id_dst_i), id_we_i, id_load_i};
                else         pipe[0] = '{0, 0, 0, 0};
            end
        end
        #1;
    endtask

    task automatic step();
        step_check();
        step_adv();
    endtask

    task automatic hold_until_issue();
        int n = 0;
        while (!last_issue && n < 20) begin
            step();
            n++;
        end
        if (!last_issue) begin
            n_chk++; n_fail++;
            $error("FAIL issue_timeout: observed no issue expected issue within 20 cycles");
        end
    endtask

    task automatic set_id(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                          input int d, input bit we, input bit ld);
        id_valid_i = v;
        id_src1_i  = IW'(s1); id_use1_i = u1;
        id_src2_i  = IW'(s2); id_use2_i = u2;
        id_dst_i   = IW'(d);  id_we_i   = we; id_load_i = ld;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < 3; a++) pipe[a] = '{0, 0, 0, 0};
        last_issue = 0;
        rst = 1; flush_i = 0; mem_stall_i = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        step(); step();
        rst = 0;

        // add x5 then sub reading x5
        set_id(1, 1, 1, 2, 1, 5, 1, 0); step();
        set_id(1, 5, 1, 3, 0, 6, 1, 0);
        step_check();
        chk("r036_fwd1", fwd1_o, BYP ? 1 : 0);
        chk("r036_stall", stall_o, BYP ? 0 : 1);
        step_adv();
        hold_until_issue();
        chk("r036_cnt", stall_cnt_o, BYP ? 0 : 3);
        drain();

        // lw x7 then add reading x7 as src2
        set_id(1, 1, 1, 0, 0, 7, 1, 1); step();
        set_id(1, 4, 1, 7, 1, 8, 1, 0);
        step_check(); chk("r037_bubble1", bubble_o, 1); chk("r037_stall1", stall_o, 1); step_adv();
        step_check(); chk("r037_bubble2", bubble_o, 1); chk("r037_state", state_o, 1); step_adv();
        step_check(); chk("r037_fwd2", fwd2_o, BYP ? 3 : 0); chk("r037_stall3", stall_o, BYP ? 0 : 1); step_adv();
        hold_until_issue();
        drain();

        // lw x0 then use x0
        set_id(1, 1, 1, 0, 0, 0, 1, 1); step();
        set_id(1, 0, 1, 0, 1, 9, 1, 0);
        step_check(); chk("r038_stall", stall_o, 0); chk("r038_fwd1", fwd1_o, 0); chk("r038_fwd2", fwd2_o, 0); step_adv();
        drain();

        // memory stall in the middle of a load-use interlock
        set_id(1, 1, 1, 0, 0, 7, 1, 1); step();
        set_id(1, 7, 1, 2, 1, 10, 1, 0); step();
        mem_stall_i = 1;
        for (int i = 0; i < 4; i++) begin
            step_check();
            chk("r039_freeze", freeze_o, 1);
            if (i > 0) chk("r039_state", state_o, 2);
            step_adv();
        end
        mem_stall_i = 0;
        step_check(); chk("r039_resume", bubble_o, 1); step_adv();
        hold_until_issue();
        drain();

        // flush together with a load-use hazard
        set_id(1, 1, 1, 0, 0, 7, 1, 1); step();
        set_id(1, 7, 1, 0, 0, 11, 1, 0); flush_i = 1;
        step_check(); chk("r040_flush", flush_o, 1); chk("r040_bubble", bubble_o, 1); chk("r040_stall", stall_o, 0); step_adv();
        flush_i = 0;
        drain();

        // reset during interlock with counter at 9
        rst = 1; step(); rst = 0;
        mem_stall_i = 1; repeat (8) step(); mem_stall_i = 0;
        set_id(1, 1, 1, 0, 0, 3, 1, 1); step();
        set_id(1, 3, 1, 0, 0, 4, 1, 0); step();
        rst = 1;
        step_check(); chk("r041_cnt9", stall_cnt_o, 9); chk("r041_state1", state_o, 1); chk("r041_rst_stall", stall_o, 0); step_adv();
        rst = 0;
        step_check(); chk("r041_state0", state_o, 0); chk("r041_cnt0", stall_cnt_o, 0); chk("r041_nostall", stall_o, 0); step_adv();
        drain();

        // random traffic; a stalled ID instruction and an unaccepted flush are held
        for (int c = 0; c < 800; c++) begin
            bit hold_id = (e_stall || e_freeze) && !rst;
            bit hold_fl = flush_i && mem_stall_i && !rst;
            rst = ($urandom_range(0, 63) == 0);
            mem_stall_i = ($urandom_range(0, 7) == 0);
            flush_i = hold_fl ? 1'b1 : ($urandom_range(0, 9) == 0);
            if (!hold_id) begin
                bit v = ($urandom_range(0, 3) != 0);
                set_id(v, $urandom_range(0, 4), v & $urandom_range(0, 1), $urandom_range(0, 4),
                       v & $urandom_range(0, 1), $urandom_range(0, 4),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
